// File: rtl/tiny_host.sv
// Host-side initiator for the pairing core: collects 32-bit beats into a wide operand,
// writes it to core RAM, runs the core with a watchdog, and streams a result word back out.
module tiny_host #(
  parameter int WORD_W  = 32,
  parameter int DATA_W  = 1188,
  parameter int BEATS   = 38,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = (1 << 20) - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [5:0]        cmd_addr,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              err_timeout,
  output logic              core_reset,
  output logic              core_sel,
  output logic [5:0]        core_addr,
  output logic              core_w,
  output logic [DATA_W-1:0] core_data,
  input  logic [DATA_W-1:0] core_out,
  input  logic              core_done
);

  localparam int PAD_W  = BEATS * WORD_W;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  LAT_LAST  = CNT_W'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_START,
    S_WAIT,
    S_RADDR,
    S_RLAT,
    S_SEND
  } state_t;

  state_t            state_q, state_d;
  logic [5:0]        addr_q, addr_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PAD_W-1:0]  data_q, data_d;
  logic              core_reset_q, core_reset_d;
  logic              err_q, err_d;
  logic              live_q, live_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      beat_q       <= '0;
      cnt_q        <= '0;
      data_q       <= '0;
      core_reset_q <= 1'b1;
      err_q        <= 1'b0;
      live_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beat_q       <= beat_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      core_reset_q <= core_reset_d;
      err_q        <= err_d;
      live_q       <= live_d;
    end
  end

  // One wide register serves as both the collect buffer (beats shifted in from the top,
  // so beat 0 ends at bit 0) and the send shifter (beats leave from the bottom).
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    beat_d       = beat_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    core_reset_d = core_reset_q;
    err_d        = err_q;
    live_d       = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && live_q) begin
          addr_d = cmd_addr;
          case (cmd_op)
            2'd0: begin
              state_d      = S_COLLECT;
              beat_d       = '0;
              core_reset_d = 1'b1;
            end
            2'd1:    state_d = S_START;
            2'd2:    state_d = S_RADDR;
            default: state_d = S_IDLE;
          endcase
        end
      end

      S_COLLECT: begin
        if (s_valid) begin
          data_d = {s_data, data_q[PAD_W-1:WORD_W]};
          if (beat_q == LAST_BEAT) begin
            state_d = S_WRITE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end

      S_WRITE: state_d = S_IDLE;

      S_START: begin
        core_reset_d = 1'b0;
        cnt_d        = '0;
        state_d      = S_WAIT;
      end

      S_WAIT: begin
        if (core_done) begin
          state_d = S_IDLE;
        end else if (cnt_q == TMO_LAST) begin
          err_d        = 1'b1;
          core_reset_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RADDR: begin
        cnt_d   = '0;
        state_d = S_RLAT;
      end

      S_RLAT: begin
        if (cnt_q == LAT_LAST) begin
          data_d  = {{(PAD_W - DATA_W){1'b0}}, core_out};
          beat_d  = '0;
          state_d = S_SEND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_SEND: begin
        if (m_ready) begin
          data_d = {{WORD_W{1'b0}}, data_q[PAD_W-1:WORD_W]};
          if (beat_q == LAST_BEAT) begin
            state_d = S_IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // live_q keeps cmd_ready low while reset is held, since state alone reads as IDLE then.
  assign cmd_ready   = live_q && (state_q == S_IDLE);
  assign s_ready     = (state_q == S_COLLECT);
  assign busy        = (state_q != S_IDLE);
  assign m_valid     = (state_q == S_SEND);
  assign m_data      = (state_q == S_SEND) ? data_q[WORD_W-1:0] : '0;
  assign m_last      = (state_q == S_SEND) && (beat_q == LAST_BEAT);
  assign err_timeout = err_q;
  assign core_reset  = core_reset_q;
  assign core_sel    = !((state_q == S_START) || (state_q == S_WAIT));
  assign core_w      = (state_q == S_WRITE);
  assign core_addr   = addr_q;
  assign core_data   = data_q[DATA_W-1:0];

endmodule

// File: tb/tb_tiny_host.sv
// Bench for tiny_host: core RAM model, table of LOAD/READ/no-op commands with a beat
// scoreboard, plus hand-written reset, RUN/done and RUN/timeout sequences.
module tb_tiny_host;
  localparam int TMO = 150;
  localparam int RDL = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [5:0]    cmd_addr = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [31:0]   s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [31:0]   m_data;
  logic          m_last;
  logic          busy;
  logic          err_timeout;
  logic          core_reset;
  logic          core_sel;
  logic [5:0]    core_addr;
  logic          core_w;
  logic [1187:0] core_data;
  logic [1187:0] core_out = '0;
  logic          core_done = 1'b0;

  tiny_host #(.RD_LAT(RDL), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .err_timeout(err_timeout), .core_reset(core_reset),
    .core_sel(core_sel), .core_addr(core_addr), .core_w(core_w),
    .core_data(core_data), .core_out(core_out), .core_done(core_done)
  );

  always #5 clk = ~clk;

  // core RAM model: port A write, registered read (RD_LAT = 1)
  logic [1187:0] ram [64];
  logic          pre_we = 1'b0;
  logic [5:0]    pre_addr = '0;
  logic [1187:0] pre_data = '0;
  int            wr_cnt = 0;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (core_sel && core_w) begin
      ram[core_addr] <= core_data;
      wr_cnt <= wr_cnt + 1;
    end
    core_out <= ram[core_addr];
  end

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;
  beat_t sbq[$];

  logic [1187:0] exp_ram [64];

  typedef struct {
    logic [1:0] op;
    logic [5:0] addr;
    int         mode;      // LOAD: 0 = k+1 pattern, 1 = random with gaps; READ: m_ready pattern
    int         exp_wr;
    int         exp_beats;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Returns at the negedge of cycle N+1, where N is the accept cycle.
  task automatic send_cmd(input logic [1:0] op, input logic [5:0] addr);
    int t;
    t = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr;
    while (!cmd_ready && t < 200) begin
      @(negedge clk); t++;
    end
    if (t >= 200) chk("cmd_accept_timeout", 64'(t), 64'(0));
    @(negedge clk);
    cmd_valid = 1'b0;
    $display("cmd op=%0d addr=%0d accepted", op, addr);
  endtask

  task automatic do_load(input logic [5:0] addr, input int mode);
    logic [31:0]   bt [38];
    logic [1215:0] buf_w;
    int k, t, w0;
    logic hs, early_w;
    buf_w = '0;
    for (int i = 0; i < 38; i++) begin
      bt[i] = (mode == 0) ? 32'(i + 1) : $urandom;
      buf_w[32*i +: 32] = bt[i];
    end
    exp_ram[addr] = buf_w[1187:0];
    w0 = wr_cnt;
    send_cmd(2'd0, addr);
    chk("load_s_ready_first", 64'(s_ready), 64'(1));
    k = 0; t = 0; early_w = 1'b0;
    while (k < 38 && t < 2000) begin
      if (core_w) early_w = 1'b1;
      if (mode != 0 && $urandom_range(0, 3) == 0) s_valid = 1'b0;
      else begin
        s_valid = 1'b1;
        s_data = bt[k];
      end
      hs = s_valid && s_ready;
      @(negedge clk); t++;
      if (hs) k++;
    end
    s_valid = 1'b0;
    chk("load_beats_taken", 64'(k), 64'(38));
    chk("load_early_write", 64'(early_w), 64'(0));
    chk("load_write_pulse", 64'(core_w), 64'(1));
    chk("load_write_addr", 64'(core_addr), 64'(addr));
    chk("load_write_data", 64'(core_data == exp_ram[addr]), 64'(1));
    if (mode == 0) begin
      chk("load_data_low", 64'(core_data[31:0]), 64'h1);
      chk("load_data_top", 64'(core_data[1187:1184]), 64'h6);
    end
    @(negedge clk);
    chk("load_write_end", 64'(core_w), 64'(0));
    chk("load_cmd_ready_back", 64'(cmd_ready), 64'(1));
    chk("load_ram_content", 64'(ram[addr] == exp_ram[addr]), 64'(1));
    $display("load addr=%0d writes=%0d", addr, wr_cnt - w0);
  endtask

  task automatic do_read(input logic [5:0] addr, input int mode, output int got);
    logic [1215:0] tmp;
    beat_t e;
    int c, t;
    logic prev_stall;
    logic [31:0] prev_d;
    tmp = {28'b0, exp_ram[addr]};
    send_cmd(2'd2, addr);
    for (int k = 0; k < 38; k++) begin
      e.data = tmp[32*k +: 32];
      e.last = (k == 37);
      sbq.push_back(e);
    end
    c = 1;
    while (!m_valid && c < 50) begin
      @(negedge clk); c++;
    end
    chk("read_latency", 64'(c), 64'(2 + RDL));
    got = 0; t = 0; prev_stall = 1'b0; prev_d = '0;
    while (sbq.size() > 0 && t < 2000) begin
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = t[0];
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (prev_stall) begin
        chk("send_hold_valid", 64'(m_valid), 64'(1));
        chk("send_hold_data", 64'(m_data), 64'(prev_d));
      end
      if (m_valid && m_ready) begin
        e = sbq.pop_front();
        chk("beat_data", 64'(m_data), 64'(e.data));
        chk("beat_last", 64'(m_last), 64'(e.last));
        got++;
      end
      prev_stall = m_valid && !m_ready;
      prev_d = m_data;
      @(negedge clk); t++;
    end
    m_ready = 1'b0;
    sbq.delete();
    chk("read_idle_after", 64'(m_valid), 64'(0));
    chk("read_busy_after", 64'(busy), 64'(0));
    $display("read addr=%0d beats=%0d", addr, got);
  endtask

  initial begin
    vec_t vecs[8];
    int w0, got, c;
    logic sel_bad, busy_bad;

    vecs[0] = '{op: 2'd0, addr: 6'd5,  mode: 0, exp_wr: 1, exp_beats: 0};
    vecs[1] = '{op: 2'd2, addr: 6'd5,  mode: 0, exp_wr: 0, exp_beats: 38};
    vecs[2] = '{op: 2'd3, addr: 6'd9,  mode: 0, exp_wr: 0, exp_beats: 0};
    vecs[3] = '{op: 2'd0, addr: 6'd17, mode: 1, exp_wr: 1, exp_beats: 0};
    vecs[4] = '{op: 2'd2, addr: 6'd17, mode: 2, exp_wr: 0, exp_beats: 38};
    vecs[5] = '{op: 2'd2, addr: 6'd3,  mode: 1, exp_wr: 0, exp_beats: 38};
    vecs[6] = '{op: 2'd0, addr: 6'd5,  mode: 1, exp_wr: 1, exp_beats: 0};
    vecs[7] = '{op: 2'd2, addr: 6'd5,  mode: 1, exp_wr: 0, exp_beats: 38};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst_s_ready", 64'(s_ready), 64'(0));
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_m_last", 64'(m_last), 64'(0));
    chk("rst_m_data", 64'(m_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(err_timeout), 64'(0));
    chk("rst_core_reset", 64'(core_reset), 64'(1));
    chk("rst_core_sel", 64'(core_sel), 64'(1));
    chk("rst_core_w", 64'(core_w), 64'(0));
    chk("rst_core_addr", 64'(core_addr), 64'(0));
    chk("rst_core_data", 64'(core_data == '0), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_rst", 64'(cmd_ready), 64'(1));

    pre_we = 1'b1; pre_addr = 6'd3; pre_data = '1;
    @(negedge clk);
    pre_we = 1'b0;
    exp_ram[3] = '1;

    // reset in the middle of COLLECT after 10 beats
    w0 = wr_cnt;
    send_cmd(2'd0, 6'd7);
    for (int k = 0; k < 10; k++) begin
      s_valid = 1'b1; s_data = 32'hA000_0000 + 32'(k);
      @(negedge clk);
    end
    s_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_s_ready", 64'(s_ready), 64'(0));
    chk("midrst_core_reset", 64'(core_reset), 64'(1));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_cmd_ready", 64'(cmd_ready), 64'(0));
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_no_write", 64'(wr_cnt - w0), 64'(0));
    $display("reset during collect applied");

    for (int i = 0; i < 8; i++) begin
      w0 = wr_cnt;
      got = 0;
      case (vecs[i].op)
        2'd0: do_load(vecs[i].addr, vecs[i].mode);
        2'd2: do_read(vecs[i].addr, vecs[i].mode, got);
        default: begin
          send_cmd(vecs[i].op, vecs[i].addr);
          chk("noop_busy", 64'(busy), 64'(0));
          chk("noop_cmd_ready", 64'(cmd_ready), 64'(1));
        end
      endcase
      chk("vec_writes", 64'(wr_cnt - w0), 64'(vecs[i].exp_wr));
      chk("vec_beats", 64'(got), 64'(vecs[i].exp_beats));
    end

    // core_done outside WAIT has no effect
    core_done = 1'b1;
    repeat (2) @(negedge clk);
    core_done = 1'b0;
    chk("done_idle_busy", 64'(busy), 64'(0));
    chk("done_idle_core_reset", 64'(core_reset), 64'(1));

    // RUN with core_done 100 cycles after core_reset falls
    send_cmd(2'd1, 6'd0);
    chk("run_start_sel", 64'(core_sel), 64'(0));
    @(negedge clk);
    chk("run_core_reset_fall", 64'(core_reset), 64'(0));
    sel_bad = 1'b0; busy_bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (core_sel) sel_bad = 1'b1;
      if (!busy) busy_bad = 1'b1;
      @(negedge clk);
    end
    core_done = 1'b1;
    chk("run_busy_before_done", 64'(busy), 64'(1));
    @(negedge clk);
    core_done = 1'b0;
    chk("run_sel_wait", 64'(sel_bad), 64'(0));
    chk("run_busy_wait", 64'(busy_bad), 64'(0));
    chk("run_busy_drop", 64'(busy), 64'(0));
    chk("run_err", 64'(err_timeout), 64'(0));
    chk("run_core_reset_held", 64'(core_reset), 64'(0));
    chk("run_sel_back", 64'(core_sel), 64'(1));
    $display("run with done complete");

    // RUN with core_done never asserted
    send_cmd(2'd1, 6'd0);
    @(negedge clk);
    chk("tmo_core_reset_fall", 64'(core_reset), 64'(0));
    c = 0; sel_bad = 1'b0;
    while (!err_timeout && c < 10 * TMO) begin
      if (core_sel) sel_bad = 1'b1;
      @(negedge clk); c++;
    end
    chk("tmo_cycles", 64'(c), 64'(TMO));
    chk("tmo_err", 64'(err_timeout), 64'(1));
    chk("tmo_core_reset", 64'(core_reset), 64'(1));
    chk("tmo_busy", 64'(busy), 64'(0));
    chk("tmo_sel_wait", 64'(sel_bad), 64'(0));
    $display("run timeout after %0d cycles", c);

    // sticky error, and the host still serves reads
    do_read(6'd17, 0, got);
    chk("post_tmo_beats", 64'(got), 64'(38));
    chk("err_sticky", 64'(err_timeout), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
